// File: rtl/tx_frame_arbiter_if.sv
// Bundle of requester and UART-side signals for tx_frame_arbiter.
// The slave modport is the arbiter's view; the master modport is its environment.
interface tx_frame_arbiter_if;
   logic        req0;
   logic [23:0] data0;
   logic        req1;
   logic [23:0] data1;
   logic        ack0;
   logic        ack1;
   logic        tx_busy;
   logic        tx_send;
   logic [7:0]  tx_data;
   logic        busy;
   logic        timeout_err;

   modport slave (
      input  req0, data0, req1, data1, tx_busy,
      output tx_send, tx_data, ack0, ack1, busy, timeout_err
   );

   modport master (
      output req0, data0, req1, data1, tx_busy,
      input  tx_send, tx_data, ack0, ack1, busy, timeout_err
   );
endinterface

// File: rtl/tx_frame_arbiter.sv
// Two-requester arbiter that serialises 24-bit frames into three bytes for a UART transmitter.
// Grants alternate on ties; every byte wait is bounded, and expired waits raise a sticky error.
module tx_frame_arbiter #(
   parameter int BUSY_WAIT = 8,
   parameter int TIMEOUT   = 1023
) (
   input  logic                clk,
   input  logic                reset,
   tx_frame_arbiter_if.slave   bus,
   output logic [2:0]          state_dbg
);
   localparam int MAX_WAIT = (BUSY_WAIT > TIMEOUT) ? BUSY_WAIT : TIMEOUT;
   localparam int TW       = $clog2(MAX_WAIT + 1);
   localparam logic [TW-1:0] BW_LAST = TW'(BUSY_WAIT - 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SEND       = 3'd1,
      WAIT_START = 3'd2,
      WAIT_DONE  = 3'd3,
      NEXT       = 3'd4,
      DONE       = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic            pend0_q, pend1_q;
   logic            last_q;
   logic            gnt_q;
   logic [23:0]     frame_q;
   logic [1:0]      idx_q;
   logic [TW-1:0]   timer_q;
   logic            err_q;

   logic grant0, grant1, timer_clr, timer_inc, idx_inc, err_set, done;

   always_comb begin
      state_d   = state_q;
      grant0    = 1'b0;
      grant1    = 1'b0;
      timer_clr = 1'b0;
      timer_inc = 1'b0;
      idx_inc   = 1'b0;
      err_set   = 1'b0;
      done      = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie the requester not served last wins.
            if (pend0_q && pend1_q) begin
               grant0 = last_q;
               grant1 = ~last_q;
            end else begin
               grant0 = pend0_q;
               grant1 = pend1_q;
            end
            if (grant0 || grant1) state_d = SEND;
         end
         SEND: begin
            timer_clr = 1'b1;
            state_d   = WAIT_START;
         end
         WAIT_START: begin
            if (bus.tx_busy) begin
               timer_clr = 1'b1;
               state_d   = WAIT_DONE;
            end else if (timer_q == BW_LAST) begin
               err_set = 1'b1;
               state_d = NEXT;
            end else begin
               timer_inc = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) begin
               state_d = NEXT;
            end else if (timer_q == TO_LAST) begin
               err_set = 1'b1;
               state_d = NEXT;
            end else begin
               timer_inc = 1'b1;
            end
         end
         NEXT: begin
            if (idx_q < 2'd2) begin
               idx_inc = 1'b1;
               state_d = SEND;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pend0_q <= 1'b0;
         pend1_q <= 1'b0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         frame_q <= '0;
         idx_q   <= '0;
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         // A new request in the same cycle as its grant keeps the flag set.
         pend0_q <= bus.req0 | (pend0_q & ~grant0);
         pend1_q <= bus.req1 | (pend1_q & ~grant1);
         if (grant0 || grant1) begin
            frame_q <= grant0 ? bus.data0 : bus.data1;
            gnt_q   <= grant1;
            idx_q   <= '0;
         end else if (idx_inc) begin
            idx_q <= idx_q + 2'd1;
         end
         if (timer_clr)      timer_q <= '0;
         else if (timer_inc) timer_q <= timer_q + TW'(1);
         if (err_set) err_q  <= 1'b1;
         if (done)    last_q <= gnt_q;
      end
   end

   always_comb begin
      case (idx_q)
         2'd0:    bus.tx_data = frame_q[23:16];
         2'd1:    bus.tx_data = frame_q[15:8];
         default: bus.tx_data = frame_q[7:0];
      endcase
   end

   assign bus.tx_send     = (state_q == SEND);
   assign bus.ack0        = (state_q == DONE) && !gnt_q;
   assign bus.ack1        = (state_q == DONE) && gnt_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.timeout_err = err_q;
   assign state_dbg       = state_q;
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter with a behavioural UART busy model.
// Bytes, send spacing, ack order and reset behaviour are checked against hand-computed values.
module tb_tx_frame_arbiter;
   localparam int BW = 8;
   localparam int TO = 60;

   logic clk = 1'b0;
   logic reset;
   logic [2:0] state_dbg;
   int cyc = 0;

   tx_frame_arbiter_if bus();

   tx_frame_arbiter #(.BUSY_WAIT(BW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // Clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // UART model: 0 = busy 20 cycles per byte, 1 = dead (never busy), 2 = busy sticks high
   int uart_mode = 0;
   int uart_cnt  = 0;
   initial begin
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         case (uart_mode)
            0: begin
               if (bus.tx_send) begin
                  bus.tx_busy = 1'b1;
                  uart_cnt    = 20;
               end else if (uart_cnt > 0) begin
                  uart_cnt--;
                  if (uart_cnt == 0) bus.tx_busy = 1'b0;
               end else begin
                  bus.tx_busy = 1'b0;
               end
            end
            1: bus.tx_busy = 1'b0;
            default: if (bus.tx_send) bus.tx_busy = 1'b1;
         endcase
      end
   end

   // Monitor
   logic [7:0] byte_q[$];
   int         send_cyc_q[$];
   int         ack_q[$];
   int         ack_cyc_q[$];
   logic       prev_send = 1'b0;
   int         dbl_send  = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (bus.tx_send) begin
            byte_q.push_back(bus.tx_data);
            send_cyc_q.push_back(cyc);
         end
         if (bus.tx_send && prev_send) dbl_send++;
         prev_send = bus.tx_send;
         if (bus.ack0) begin ack_q.push_back(0); ack_cyc_q.push_back(cyc); end
         if (bus.ack1) begin ack_q.push_back(1); ack_cyc_q.push_back(cyc); end
      end
   end

   // Scoreboard
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic [23:0] d);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
   endtask

   task automatic check_bytes(input string tag);
      check({tag, "_count"}, byte_q.size(), exp_q.size());
      while (exp_q.size() > 0 && byte_q.size() > 0)
         check(tag, byte_q.pop_front(), exp_q.pop_front());
      exp_q.delete();
      byte_q.delete();
   endtask

   task automatic check_timing(input string tag, input int req_cyc, input int sp);
      if (send_cyc_q.size() >= 3 && ack_cyc_q.size() >= 1) begin
         check({tag, "_first_send"}, send_cyc_q[0] - req_cyc, 2);
         check({tag, "_gap01"}, send_cyc_q[1] - send_cyc_q[0], sp);
         check({tag, "_gap12"}, send_cyc_q[2] - send_cyc_q[1], sp);
         check({tag, "_ack_gap"}, ack_cyc_q[0] - send_cyc_q[2], sp);
      end else begin
         check({tag, "_sends"}, send_cyc_q.size(), 3);
      end
   endtask

   task automatic clear_logs();
      byte_q.delete(); send_cyc_q.delete(); ack_q.delete(); ack_cyc_q.delete(); exp_q.delete();
   endtask

   // Driver tasks
   int last_req_cyc;
   task automatic pulse_req(input int who, input logic [23:0] d);
      @(negedge clk);
      if (who == 0) begin bus.data0 = d; bus.req0 = 1'b1; end
      else          begin bus.data1 = d; bus.req1 = 1'b1; end
      last_req_cyc = cyc;
      @(negedge clk);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (ack_q.size() < n && k < budget) begin @(negedge clk); k++; end
      check("ack_wait", ack_q.size(), n);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_send"}, bus.tx_send, 0);
      check({tag, "_tx_data"}, bus.tx_data, 0);
      check({tag, "_ack"}, {bus.ack0, bus.ack1}, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_err"}, bus.timeout_err, 0);
      check({tag, "_state"}, state_dbg, 0);
   endtask

   initial begin
      reset = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      bus.data0 = '0;  bus.data1 = '0;

      // Reset values, and requests during reset are discarded
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      @(negedge clk);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      reset = 1'b0;
      clear_logs();
      repeat (10) @(negedge clk);
      check("reset_req_discarded", send_cyc_q.size(), 0);
      check("reset_idle_busy", bus.busy, 0);

      // Single frame through a well-behaved UART
      clear_logs();
      pulse_req(0, 24'hA1B2C3);
      wait_acks(1, 300);
      push_frame(24'hA1B2C3);
      check_bytes("single_bytes");
      check_timing("single", last_req_cyc, 22);
      if (ack_q.size() > 0) check("single_ack_id", ack_q[0], 0);
      check("single_err", bus.timeout_err, 0);

      // Tie straight after reset: requester 0 first
      apply_reset();
      clear_logs();
      @(negedge clk);
      bus.data0 = 24'h111213; bus.data1 = 24'h212223;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      @(negedge clk);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      wait_acks(2, 400);
      push_frame(24'h111213);
      push_frame(24'h212223);
      check_bytes("tie_bytes");
      if (ack_q.size() >= 2) begin
         check("tie_ack_first", ack_q[0], 0);
         check("tie_ack_second", ack_q[1], 1);
      end

      // Fairness: both keep re-requesting, grants alternate
      clear_logs();
      @(negedge clk);
      bus.data0 = 24'h300000; bus.data1 = 24'h400000;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      @(negedge clk);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_acks(k + 1, 300);
         if (ack_q.size() > k) pulse_req(ack_q[k], 24'h500000 + k);
      end
      wait_acks(5, 800);
      repeat (40) @(negedge clk);
      check("fair_ack_total", ack_q.size(), 5);
      if (ack_q.size() >= 5) begin
         check("fair_ack0", ack_q[0], 0);
         check("fair_ack1", ack_q[1], 1);
         check("fair_ack2", ack_q[2], 0);
         check("fair_ack3", ack_q[3], 1);
         check("fair_ack4", ack_q[4], 0);
      end

      // Dead UART: each byte waits BUSY_WAIT cycles and still goes out
      clear_logs();
      uart_mode = 1;
      pulse_req(0, 24'h0A0B0C);
      wait_acks(1, 300);
      push_frame(24'h0A0B0C);
      check_bytes("dead_bytes");
      check_timing("dead", last_req_cyc, BW + 2);
      check("dead_err", bus.timeout_err, 1);
      repeat (5) @(negedge clk);
      check("dead_err_sticky", bus.timeout_err, 1);

      // Stuck busy: each byte times out in WAIT_DONE, frame still completes
      clear_logs();
      uart_mode = 2;
      pulse_req(1, 24'h5A5B5C);
      wait_acks(1, 600);
      push_frame(24'h5A5B5C);
      check_bytes("stuck_bytes");
      check_timing("stuck", last_req_cyc, TO + 3);
      if (ack_q.size() > 0) check("stuck_ack_id", ack_q[0], 1);
      check("stuck_err", bus.timeout_err, 1);
      uart_mode = 0;
      repeat (3) @(negedge clk);

      // Reset in the middle of byte 2 with requester 1 pending
      clear_logs();
      pulse_req(0, 24'hC0FFEE);
      begin
         int k = 0;
         while (send_cyc_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
      end
      check("midreset_sends_before", send_cyc_q.size(), 2);
      pulse_req(1, 24'h123456);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("midreset");
      check("midreset_no_ack", ack_q.size(), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_logs();
      repeat (60) @(negedge clk);
      check("post_reset_no_send", send_cyc_q.size(), 0);
      check("post_reset_no_ack", ack_q.size(), 0);
      check("post_reset_busy", bus.busy, 0);

      check("no_back_to_back_send", dbl_send, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/tx_frame_arbiter.md
TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

Interface
REQ-001 SHALL have parameter BUSY_WAIT, default 8: maximum cycles to wait for tx_busy to rise after a tx_send pulse.
REQ-002 SHALL have parameter TIMEOUT, default 1023: maximum cycles to wait for tx_busy to fall once it has risen.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req0  input  1  requester 0 frame request, one-cycle pulse.
REQ-006 SHALL have port data0  input  24  requester 0 frame payload; held stable by requester from req0 until ack0.
REQ-007 SHALL have port req1  input  1  requester 1 frame request, one-cycle pulse.
REQ-008 SHALL have port data1  input  24  requester 1 frame payload; held stable by requester from req1 until ack1.
REQ-009 SHALL have port tx_busy  input  1  UART transmitter busy.
REQ-010 SHALL have port tx_send  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 SHALL have port tx_data  output  8  byte presented to the UART transmitter.
REQ-012 SHALL have port ack0  output  1  one-cycle pulse: requester 0 frame finished.
REQ-013 SHALL have port ack1  output  1  one-cycle pulse: requester 1 frame finished.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port timeout_err  output  1  sticky flag: at least one byte wait timed out.

Function
REQ-016 SHALL latch each reqN pulse into a pending flag pendN; when set and clear coincide, set SHALL win.
REQ-017 SHALL use states IDLE, SEND, WAIT_START, WAIT_DONE, NEXT, DONE.
REQ-018 IDLE: if no pending flag is set, SHALL stay in IDLE.
REQ-019 IDLE: if exactly one pending flag is set, SHALL grant that requester.
REQ-020 IDLE: if both pending flags are set, SHALL grant the requester not served last; after reset, last served = 1, so requester 0 wins the first tie.
REQ-021 On grant, SHALL copy the granted data into a 24-bit frame register, clear that requester's pending flag, set byte index to 0, and go to SEND.
REQ-022 Byte order SHALL be frame[23:16], then frame[15:8], then frame[7:0].
REQ-023 SEND: SHALL assert tx_send for exactly one cycle, clear the wait timer, and go to WAIT_START.
REQ-024 tx_data SHALL show the current byte from the SEND cycle through the end of that byte's wait.
REQ-025 WAIT_START: if tx_busy=1, SHALL clear the timer and go to WAIT_DONE.
REQ-026 WAIT_START: else if timer = BUSY_WAIT-1, SHALL set timeout_err and go to NEXT.
REQ-027 WAIT_START: otherwise SHALL increment the timer.
REQ-028 WAIT_DONE: if tx_busy=0, SHALL go to NEXT.
REQ-029 WAIT_DONE: else if timer = TIMEOUT-1, SHALL set timeout_err and go to NEXT.
REQ-030 WAIT_DONE: otherwise SHALL increment the timer.
REQ-031 NEXT: if byte index < 2, SHALL increment the index and go to SEND.
REQ-032 NEXT: if byte index = 2, SHALL go to DONE.
REQ-033 DONE: SHALL pulse ackN of the granted requester for one cycle, record it as last served, and go to IDLE.
REQ-034 reqN pulses arriving during a frame SHALL be queued in pendN and SHALL NOT disturb the frame in progress.
REQ-035 A second reqN from a requester whose pendN is already set SHALL merge with the first (no counting).
REQ-036 Latency: a req pulse in cycle C with the arbiter idle SHALL produce the first tx_send in cycle C+2.
REQ-037 The timer SHALL be wide enough for max(BUSY_WAIT, TIMEOUT) and SHALL never wrap within a wait.
REQ-038 tx_send SHALL never be asserted in consecutive cycles.

Reset
REQ-039 While reset=1, the block SHALL hold: state IDLE; pend0/pend1 = 0; last served = 1; tx_send = 0; tx_data = 0; ack0/ack1 = 0; busy = 0; timeout_err = 0; timer = 0; byte index = 0.
REQ-040 Reset asserted mid-frame SHALL abort the frame immediately, with no ack and no further tx_send.
REQ-041 Requests arriving during reset SHALL be discarded.

Verification
REQ-042 Single frame: req0 pulse with data0=0xA1B2C3; UART model busy for 20 cycles per byte -> tx_data A1, B2, C3, three tx_send pulses, first tx_send 2 cycles after req0, then one ack0 pulse; timeout_err=0.
REQ-043 Tie: req0 and req1 in the same cycle after reset -> requester 0 frame sent in full, then requester 1 frame; ack0 precedes ack1.
REQ-044 Fairness: both requesters re-request immediately on every ack -> grants strictly alternate 0,1,0,1 over 4 frames.
REQ-045 Dead UART: tx_busy stuck at 0 -> each byte waits BUSY_WAIT cycles; all three bytes are still attempted; ack pulses; timeout_err=1 and stays 1.
REQ-046 Stuck busy: tx_busy stuck at 1 after the first byte -> that byte times out after TIMEOUT cycles; remaining bytes proceed; timeout_err=1.
REQ-047 Reset mid-frame: reset asserted during byte 2, req1 pending -> all outputs at reset values; after release no tx_send until a new request arrives.
